object_state_renderer: RTL

// Consumer end of the per-frame object-state bus ({img_id,x,y,width,height}, 5 x 11 bit) driven by the scroll/background controllers.

---
 rtl/object_state_renderer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/object_state_renderer.sv
// Object-state consumer: snapshots the per-frame object state, normalises the scrolled y
// into [0,height) with a small FSM, then renders hit/offsets/ROM address per pixel.
module object_state_renderer #(
  parameter int FIELD_W       = 11,
  parameter int ADDR_W        = 18,
  parameter int MAX_NORM_ITER = 31
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    frame_start,
  input  logic [0:4][0:FIELD_W-1] obj_state,
  input  logic                    pixel_valid,
  input  logic [FIELD_W-1:0]      pixelX,
  input  logic [FIELD_W-1:0]      pixelY,
  output logic                    draw_valid,
  output logic                    drawing_request,
  output logic [FIELD_W-1:0]      img_id_out,
  output logic [FIELD_W-1:0]      offsetX,
  output logic [FIELD_W-1:0]      offsetY,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic                    busy,
  output logic                    norm_err,
  output logic [1:0]              dbg_state
);
  // Pixel stream is valid-only with no backpressure: a pixel is accepted on every cycle
  // pixel_valid is high and its result appears with draw_valid exactly two cycles later.
  localparam int YW     = FIELD_W + 2;
  localparam int ITER_W = $clog2(MAX_NORM_ITER + 2);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_NORM_ITER);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_NORM = 2'd1, ST_READY = 2'd2} state_e;

  state_e                   state_q, state_d;
  logic [ITER_W-1:0]        iter_q, iter_d;
  logic signed [YW-1:0]     y_norm_q, y_norm_d;
  logic                     norm_err_q, norm_err_d;
  logic [FIELD_W-1:0]       img_id_q, img_id_d, x_q, x_d, width_q, width_d, height_q, height_d;
  logic [FIELD_W-1:0]       y_in;

  logic signed [YW-1:0]     height_s, dy_raw, dy_wrap;
  logic [FIELD_W:0]         x_end;
  logic                     hit_x, hit_y, y_neg, in_range;

  logic                     s1_valid_q, s1_valid_d, s1_hit_q, s1_hit_d;
  logic [FIELD_W-1:0]       s1_offx_q, s1_offx_d, s1_dy_q, s1_dy_d;
  logic [FIELD_W-1:0]       s1_width_q, s1_width_d, s1_img_q, s1_img_d;

  logic                     dv_q, dv_d, dr_q, dr_d;
  logic [FIELD_W-1:0]       img_out_q, img_out_d, offx_q, offx_d, offy_q, offy_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [2*FIELD_W-1:0]     prod;

  assign y_in = obj_state[2];

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      iter_q     <= '0;
      y_norm_q   <= '0;
      norm_err_q <= 1'b0;
      img_id_q   <= '0;
      x_q        <= '0;
      width_q    <= '0;
      height_q   <= '0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      y_norm_q   <= y_norm_d;
      norm_err_q <= norm_err_d;
      img_id_q   <= img_id_d;
      x_q        <= x_d;
      width_q    <= width_d;
      height_q   <= height_d;
    end
  end

  // One add or subtract of height per NORM cycle until y_norm lands in [0,height).
  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    y_norm_d   = y_norm_q;
    norm_err_d = 1'b0;
    img_id_d   = img_id_q;
    x_d        = x_q;
    width_d    = width_q;
    height_d   = height_q;
    if (frame_start) begin
      img_id_d = obj_state[0];
      x_d      = obj_state[1];
      width_d  = obj_state[3];
      height_d = obj_state[4];
      y_norm_d = {{2{y_in[FIELD_W-1]}}, y_in};
      iter_d   = '0;
      state_d  = ST_NORM;
    end else if (state_q == ST_NORM) begin
      if (width_q == '0 || height_q == '0 || in_range) begin
        state_d = ST_READY;
      end else if (iter_q > ITER_MAX) begin
        y_norm_d   = '0;
        norm_err_d = 1'b1;
        state_d    = ST_READY;
      end else begin
        iter_d   = iter_q + ITER_W'(1);
        y_norm_d = y_neg ? y_norm_q + height_s : y_norm_q - height_s;
      end
    end
  end

  always_comb begin
    height_s = $signed({2'b00, height_q});
    y_neg    = y_norm_q[YW-1];
    in_range = !y_neg && (y_norm_q < height_s);
    x_end    = {1'b0, x_q} + {1'b0, width_q};
    hit_x    = (pixelX >= x_q) && ({1'b0, pixelX} < x_end);
    dy_raw   = $signed({2'b00, pixelY}) - y_norm_q;
    dy_wrap  = dy_raw[YW-1] ? dy_raw + height_s : dy_raw;
    hit_y    = dy_wrap < height_s;
    s1_valid_d = pixel_valid;
    s1_hit_d   = pixel_valid && hit_x && hit_y && (state_q == ST_READY) &&
                 (width_q != '0) && (height_q != '0);
    s1_offx_d  = pixelX - x_q;
    s1_dy_d    = dy_wrap[FIELD_W-1:0];
    s1_width_d = width_q;
    s1_img_d   = img_id_q;
  end

  always_comb begin
    prod      = {{FIELD_W{1'b0}}, s1_dy_q} * {{FIELD_W{1'b0}}, s1_width_q};
    dv_d      = s1_valid_q;
    dr_d      = s1_hit_q;
    img_out_d = '0;
    offx_d    = '0;
    offy_d    = '0;
    addr_d    = '0;
    if (s1_hit_q) begin
      img_out_d = s1_img_q;
      offx_d    = s1_offx_q;
      offy_d    = s1_dy_q;
      addr_d    = ADDR_W'(prod + {{FIELD_W{1'b0}}, s1_offx_q});
    end
  end

  // Stage 1 captures everything it needs, so a later frame_start cannot disturb pixels in flight.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_offx_q  <= '0;
      s1_dy_q    <= '0;
      s1_width_q <= '0;
      s1_img_q   <= '0;
      dv_q       <= 1'b0;
      dr_q       <= 1'b0;
      img_out_q  <= '0;
      offx_q     <= '0;
      offy_q     <= '0;
      addr_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_hit_q   <= s1_hit_d;
      s1_offx_q  <= s1_offx_d;
      s1_dy_q    <= s1_dy_d;
      s1_width_q <= s1_width_d;
      s1_img_q   <= s1_img_d;
      dv_q       <= dv_d;
      dr_q       <= dr_d;
      img_out_q  <= img_out_d;
      offx_q     <= offx_d;
      offy_q     <= offy_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    busy            = (state_q == ST_NORM);
    norm_err        = norm_err_q;
    dbg_state       = state_q;
    draw_valid      = dv_q;
    drawing_request = dr_q;
    img_id_out      = img_out_q;
    offsetX         = offx_q;
    offsetY         = offy_q;
    rom_addr        = addr_q;
  end
endmodule
